// File: rtl/uart_rx.sv
// uart_rx: serial byte receiver for the uart_tx line format.
// Frame: start bit (0), 8 data bits MSB first, stop bit (1).
// Recovered bytes leave over a valid/ready port. Framing errors are reported
// as a one-cycle pulse. Overruns are reported as a sticky flag.
// Optional build macro UART_RX_SYNC_EN: rx passes through a 2-flop
// synchroniser before use. This adds exactly 2 cycles of latency.
// dbg_state exposes the FSM state encoding for checkers.
//
// Handshake: data is stable while valid=1. A byte transfers on any rising CLK
// edge with valid&&ready. valid then drops unless a new byte lands on that same
// edge. A byte completing while valid&&!ready is dropped and sets overrun.
// overrun clears on the next accepted transfer.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       rx,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_err,
  output logic       overrun,
  output logic [2:0] dbg_state
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-stage synchroniser. It resets to the idle-high line level.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ovr_q, ovr_d;
  logic          frame_done;
  logic          frame_bad;

  // State and datapath registers. Reset discards any partial frame.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd7;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
    end
  end

  // Frame FSM. The IDLE detection edge is offset 0 of the start bit.
  // START re-samples when its countdown reaches zero, which is HALF edges
  // after detection. DATA and STOP sample whenever the counter reads zero,
  // which is one full bit period after the previous sample.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          if (HALF == 0) begin
            state_d   = S_DATA;
            cnt_d     = LAST_C;
            bit_idx_d = 3'd7;
          end else begin
            state_d = S_START;
            cnt_d   = HALF_C;
          end
        end
      end
      S_START: begin
        if (cnt_q == ONE_C) begin
          if (!rx_s) begin
            state_d   = S_DATA;
            cnt_d     = LAST_C;
            bit_idx_d = 3'd7;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d[bit_idx_q] = rx_s;
          cnt_d              = LAST_C;
          if (bit_idx_q == 3'd0) begin
            state_d   = S_STOP;
            bit_idx_d = 3'd7;
          end else begin
            bit_idx_d = bit_idx_q - 3'd1;
          end
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          cnt_d = '0;
          if (rx_s) begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      S_BREAK: begin
        // A held-low line must return high before the next frame can start.
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register, handshake, and error flags.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    fe_d    = frame_bad;
    if (valid_q && ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (frame_done) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign framing_err = fe_q;
  assign overrun     = ovr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: bench for uart_rx with two instances.
// u1 uses CLKS_PER_BIT=1 and u4 uses CLKS_PER_BIT=4.
// Expected bytes are queued when a frame is driven. They are compared when
// the DUT hands the byte over.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // clock / reset
  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic       rx1 = 1'b1, ready1 = 1'b1, valid1, fe1, ovr1;
  logic       rx4 = 1'b1, ready4 = 1'b1, valid4, fe4, ovr4;
  logic [7:0] data1, data4;
  logic [2:0] st1, st4;

  uart_rx #(.CLKS_PER_BIT(1)) u1 (
    .CLK(CLK), .RESETN(RESETN), .rx(rx1), .ready(ready1), .data(data1),
    .valid(valid1), .framing_err(fe1), .overrun(ovr1), .dbg_state(st1)
  );

  uart_rx #(.CLKS_PER_BIT(4)) u4 (
    .CLK(CLK), .RESETN(RESETN), .rx(rx4), .ready(ready4), .data(data4),
    .valid(valid4), .framing_err(fe4), .overrun(ovr4), .dbg_state(st4)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q4[$];
  int vcnt1 = 0, vcnt4 = 0, fecnt1 = 0, fecnt4 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Output monitor: compare each accepted byte against the expected queue.
  always @(negedge CLK) begin
    if (RESETN) begin
      if (valid1 && ready1) begin
        vcnt1++;
        if (exp_q1.size() == 0) begin
          n_checks++;
          $display("FAIL u1 unexpected byte: got %0h expected none", data1);
        end else begin
          check("u1 data", data1, exp_q1.pop_front());
        end
      end
      if (valid4 && ready4) begin
        vcnt4++;
        if (exp_q4.size() == 0) begin
          n_checks++;
          $display("FAIL u4 unexpected byte: got %0h expected none", data4);
        end else begin
          check("u4 data", data4, exp_q4.pop_front());
        end
      end
      if (fe1) fecnt1++;
      if (fe4) fecnt4++;
    end
  end

  // driver tasks
  task automatic set_rx(input int sel, input logic v);
    if (sel == 1) rx1 = v;
    else          rx4 = v;
  endtask

  // Hold one bit for n cycles. When corrupt is set, only offset 1 carries
  // the true value.
  task automatic drive_bit(input int sel, input logic v, input int n, input bit corrupt);
    logic x;
    for (int k = 0; k < n; k++) begin
      x = (corrupt && k != 1) ? ~v : v;
      set_rx(sel, x);
      @(posedge CLK); #1;
    end
  endtask

  task automatic send_frame(input int sel, input logic [7:0] b, input logic stop_bit, input bit corrupt);
    int n;
    n = (sel == 1) ? 1 : 4;
    drive_bit(sel, 1'b0, n, 1'b0);
    for (int i = 7; i >= 0; i--) drive_bit(sel, b[i], n, corrupt);
    drive_bit(sel, stop_bit, n, 1'b0);
  endtask

  task automatic idle(input int sel, input int n);
    set_rx(sel, 1'b1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic wait_valid(input int sel, input int max_cyc, output int lat);
    int t0;
    t0  = cyc;
    lat = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK);
      if ((sel == 1) ? valid1 : valid4) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    bit         corrupt;
    int         exp_v;
    int         exp_fe;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int lat, v0, f0;
    logic [7:0] r;

    vecs[0] = '{8'h00, 1'b1, 1'b0, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 1'b0, 1, 0};
    vecs[2] = '{8'h81, 1'b1, 1'b1, 1, 0};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 0, 1};
    vecs[4] = '{8'($urandom_range(0, 255)), 1'b1, 1'b1, 1, 0};
    vecs[5] = '{8'($urandom_range(0, 255)), 1'b1, 1'b0, 1, 0};

    // reset state
    repeat (3) @(posedge CLK);
    #1;
    check("u1 reset data", data1, 8'h00);
    check("u1 reset valid", valid1, 1'b0);
    check("u1 reset fe", fe1, 1'b0);
    check("u1 reset ovr", ovr1, 1'b0);
    check("u1 reset state", st1, ST_IDLE);
    check("u4 reset data", data4, 8'h00);
    check("u4 reset valid", valid4, 1'b0);
    check("u4 reset state", st4, ST_IDLE);
    RESETN = 1'b1;
    idle(1, 3);

    // CLKS_PER_BIT=1 latency: valid from t+10 for a single cycle
    exp_q1.push_back(8'hA5);
    fork
      send_frame(1, 8'hA5, 1'b1, 1'b0);
      wait_valid(1, 40, lat);
    join
    check("u1 latency", lat, 10 + SYNC);
    @(negedge CLK);
    check("u1 valid one cycle", valid1, 1'b0);
    check("u1 no fe", fecnt1, 0);
    check("u1 no ovr", ovr1, 1'b0);
    idle(1, 2);

    // CLKS_PER_BIT=4: samples at offset 1, valid one cycle after stop sample
    exp_q4.push_back(8'h3C);
    fork
      send_frame(4, 8'h3C, 1'b1, 1'b1);
      wait_valid(4, 80, lat);
    join
    check("u4 latency", lat, 38 + SYNC);
    idle(4, 4);

    // false start
    v0 = vcnt4; f0 = fecnt4;
    rx4 = 1'b0;
    @(posedge CLK); #1;
    idle(4, 8);
    check("false start state", st4, ST_IDLE);
    check("false start valid", valid4, 1'b0);
    check("false start fe", fecnt4 - f0, 0);
    check("false start ovr", ovr4, 1'b0);
    check("false start no byte", vcnt4 - v0, 0);

    // table of frames on u4
    for (int i = 0; i < 6; i++) begin
      v0 = vcnt4; f0 = fecnt4;
      if (vecs[i].exp_v != 0) exp_q4.push_back(vecs[i].b);
      send_frame(4, vecs[i].b, vecs[i].stop, vecs[i].corrupt);
      idle(4, 6);
      check($sformatf("vec%0d valid count", i), vcnt4 - v0, vecs[i].exp_v);
      check($sformatf("vec%0d fe count", i), fecnt4 - f0, vecs[i].exp_fe);
    end

    // bad stop bit followed by a held-low line
    v0 = vcnt1; f0 = fecnt1;
    send_frame(1, 8'hFF, 1'b0, 1'b0);
    rx1 = 1'b0;
    repeat (20) begin @(posedge CLK); #1; end
    check("break state", st1, ST_BREAK);
    check("break one fe pulse", fecnt1 - f0, 1);
    check("break no byte", vcnt1 - v0, 0);
    idle(1, 3 + SYNC);
    check("break released", st1, ST_IDLE);
    exp_q1.push_back(8'h12);
    send_frame(1, 8'h12, 1'b1, 1'b0);
    idle(1, 4);
    check("after break byte", vcnt1 - v0, 1);

    // back-to-back frames with no idle bits
    v0 = vcnt1;
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom_range(0, 255));
      exp_q1.push_back(r);
      send_frame(1, r, 1'b1, 1'b0);
    end
    idle(1, 5);
    check("back-to-back count", vcnt1 - v0, 3);

    // overrun
    ready1 = 1'b0;
    exp_q1.push_back(8'h11);
    send_frame(1, 8'h11, 1'b1, 1'b0);
    send_frame(1, 8'h22, 1'b1, 1'b0);
    idle(1, 5);
    check("overrun valid held", valid1, 1'b1);
    check("overrun data kept", data1, 8'h11);
    check("overrun flag", ovr1, 1'b1);
    ready1 = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("overrun valid cleared", valid1, 1'b0);
    check("overrun flag cleared", ovr1, 1'b0);
    idle(1, 2);

    // reset during data bit 3 of 8'h55
    drive_bit(1, 1'b0, 1, 1'b0);
    for (int i = 7; i >= 4; i--) drive_bit(1, r[0] ^ r[0] ^ ((8'h55 >> i) & 8'h01) != 0, 1, 1'b0);
    rx1 = 1'b0;
    #2;
    RESETN = 1'b0;
    #1;
    check("midframe reset state", st1, ST_IDLE);
    check("midframe reset data", data1, 8'h00);
    check("midframe reset valid", valid1, 1'b0);
    rx1 = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESETN = 1'b1;
    idle(1, 3);
    v0 = vcnt1;
    exp_q1.push_back(8'h0F);
    send_frame(1, 8'h0F, 1'b1, 1'b0);
    idle(1, 6);
    check("after reset one byte", vcnt1 - v0, 1);

    // final report
    check("u1 queue drained", exp_q1.size(), 0);
    check("u4 queue drained", exp_q4.size(), 0);
    check("u4 no ovr", ovr4, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
